// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the BCD serialiser.
package bcd_pkg;
    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;
endpackage

// File: rtl/bcd_serial_tx_if.sv
// Digit handshake plus serial outputs of the BCD serialiser.
interface bcd_serial_tx_if;
    import bcd_pkg::*;

    logic [DIGIT_W-1:0] din;
    logic               din_valid;
    logic               din_ready;
    logic               x;
    logic               frame;
    logic               busy;
    logic               bcd_err;

    modport master (
        output din, din_valid,
        input  din_ready, x, frame, busy, bcd_err
    );

    modport slave (
        input  din, din_valid,
        output din_ready, x, frame, busy, bcd_err
    );
endinterface

// File: rtl/bcd_fifo2.sv
// Two-entry digit FIFO; simultaneous push and pop allowed whenever not full.
module bcd_fifo2
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    logic [DIGIT_W-1:0] mem [2];
    logic               wp, rp;
    logic [1:0]         cnt;

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign dout  = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/bcd_serial_tx.sv
// Parallel BCD digit to serial bit stream with optional inter-digit idle gap.
// Build option: BCD_SERIAL_TX_BCD_CHECK_EN drops digits above 9 and pulses bcd_err.
module bcd_serial_tx
    import bcd_pkg::*;
#(
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_serial_tx_if.slave bus
);
    localparam logic [1:0] GAP_LAST = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

    state_t             state;
    logic [1:0]         cnt;
    logic [1:0]         gcnt;
    logic [DIGIT_W-1:0] sr;
    logic [DIGIT_W-1:0] shifted;
    logic [DIGIT_W-1:0] head;
    logic               bit_out;
    logic               take, push, pop, full, empty, seq_end;

    assign take = bus.din_valid && bus.din_ready;

`ifdef BCD_SERIAL_TX_BCD_CHECK_EN
    logic bad, err_q;
    assign bad  = (bus.din > DIGIT_W'(BCD_MAX));
    assign push = take && !bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= take && bad;
    end
    assign bus.bcd_err = err_q;
`else
    assign push        = take;
    assign bus.bcd_err = 1'b0;
`endif

    bcd_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // End of a digit (or of its trailing gap): the next queued digit may start here.
    assign seq_end = ((state == ST_SHIFT) && (cnt == 2'd3) && (GAP_CYCLES == 0)) ||
                     ((state == ST_GAP) && (gcnt == GAP_LAST));
    assign pop     = !empty && ((state == ST_IDLE) || seq_end);

    assign shifted = (MSB_FIRST != 0) ? {sr[DIGIT_W-2:0], 1'b0} : {1'b0, sr[DIGIT_W-1:1]};
    assign bit_out = (MSB_FIRST != 0) ? sr[DIGIT_W-1] : sr[0];

    assign bus.din_ready = !full;
    assign bus.x         = (state == ST_SHIFT) && bit_out;
    assign bus.frame     = (state == ST_SHIFT) && (cnt == 2'd0);
    assign bus.busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
            gcnt  <= 2'd0;
            sr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        sr    <= head;
                        cnt   <= 2'd0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt + 2'd1;
                    sr  <= shifted;
                    if (cnt == 2'd3) begin
                        if (GAP_CYCLES > 0) begin
                            state <= ST_GAP;
                            gcnt  <= 2'd0;
                        end else if (pop) begin
                            sr  <= head;
                            cnt <= 2'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    gcnt <= gcnt + 2'd1;
                    if (seq_end) begin
                        if (pop) begin
                            sr    <= head;
                            cnt   <= 2'd0;
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/bcd_serial_tx.md
BCD_SERIAL_TX -- requirements
Module: bcd_serial_tx

Interface
REQ-001 Parameter MSB_FIRST, default 1, meaning: 1 shifts bit 3 first, 0 shifts bit 0 first.
REQ-002 Parameter GAP_CYCLES, default 0, meaning: idle cycles (x=0) inserted between consecutive digits, range 0..3.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 din  input  4  parallel BCD digit.
REQ-006 din_valid  input  1  din holds a digit to transfer.
REQ-007 din_ready  output  1  block can accept a digit this cycle.
REQ-008 x  output  1  serial data bit; feeds the downstream BCD odd-parity generator input x.
REQ-009 frame  output  1  high during the first bit of each digit.
REQ-010 busy  output  1  shifter is active (SHIFT or GAP state).
REQ-011 bcd_err  output  1  one-cycle pulse when a non-BCD digit is rejected (see Configuration).

Function
REQ-012 Transfer occurs on a rising edge where din_valid and din_ready are both 1; no other edge transfers.
REQ-013 Accepted digits enter a 2-entry FIFO; din_ready = FIFO not full; full and accept in the same cycle as a pop is permitted only when not full.
REQ-014 FSM states: IDLE, SHIFT, GAP.
REQ-015 IDLE: when FIFO is non-empty, pop the head into a 4-bit shift register and a 2-bit bit counter = 0, then go to SHIFT; x=0, frame=0 while in IDLE.
REQ-016 SHIFT: x = current bit (bit 3 down to bit 0 if MSB_FIRST, else bit 0 up to bit 3); frame=1 only when counter=0; the counter increments each cycle.
REQ-017 SHIFT with counter=3: if GAP_CYCLES>0, go to GAP; else, if FIFO is non-empty, pop and restart SHIFT with counter=0 (back-to-back, no bubble); otherwise go to IDLE.
REQ-018 GAP: x=0 for exactly GAP_CYCLES cycles, then behave as the SHIFT counter=3 exit with GAP_CYCLES treated as 0.
REQ-019 Latency: a digit accepted at edge N into an empty FIFO in IDLE produces its first bit (frame=1) during the cycle after edge N+1, i.e. x/frame are registered.
REQ-020 Every digit produces exactly 4 consecutive x bits; a digit is never truncated or repeated.
REQ-021 din is sampled only at transfer; later changes to din do not alter queued digits.
REQ-022 busy=1 in SHIFT and GAP, else 0.

Reset
REQ-023 On reset=0: FIFO empty, FSM=IDLE, counter=0, shift register=0, x=0, frame=0, busy=0, bcd_err=0; din_ready=1 once reset=1.
REQ-024 Reset asserted mid-digit aborts the digit immediately; queued digits are discarded; no partial bits appear after release.

Configuration
REQ-025 Macro BCD_SERIAL_TX_BCD_CHECK_EN.
REQ-026 Defined: at a transfer where din>9, the digit is not queued and bcd_err pulses for one cycle on the next cycle; din_ready is unaffected.
REQ-027 Undefined: every value 0..15 is queued and shifted; bcd_err is tied to 0.

Structure
REQ-028 Shared package bcd_pkg holds DIGIT_W=4, BCD_MAX=9, and the FSM state typedef (IDLE, SHIFT, GAP).
REQ-029 The 2-entry FIFO is the sub-module bcd_fifo2 (push, pop, full, empty, dout); the FSM and shifter live in bcd_serial_tx.

Verification
REQ-030 Reset release, din=4'b0101 valid 1 cycle -> frame high one cycle later, x = 0,1,0,1 on consecutive cycles, then IDLE with x=0.
REQ-031 Digits 9, 0, 3 presented back-to-back with GAP_CYCLES=0 -> x = 1001 0000 0011 with no bubbles; din_ready drops after two queued digits and recovers.
REQ-032 GAP_CYCLES=2, digits 1, 2 -> x = 0001 00 0010; busy stays high across the gap.
REQ-033 With macro defined, din=4'd12 then 4'd7 -> bcd_err pulses once, only 0111 is shifted; with macro undefined -> 1100 0111 is shifted and bcd_err stays 0.
REQ-034 reset=0 asserted during the second bit of digit 8 with one digit queued -> x=0 immediately, FIFO empty, no bits emitted after release until new input.
REQ-035 MSB_FIRST=0, digit 4'b0011 -> x = 1,1,0,0.
